// File: rtl/uart_cmd_responder_if.sv
// Byte-stream handshake between the UART FIFOs and the command responder.
// The responder owns the pop/push strobes and the outgoing byte; the FIFO
// side owns the empty/full flags and the incoming head byte.
interface uart_cmd_responder_if #(
    parameter int DBIT = 8
);
    logic            rx_empty;
    logic [DBIT-1:0] r_data;
    logic            rd_uart;
    logic            tx_full;
    logic [DBIT-1:0] w_data;
    logic            wr_uart;

    modport master (
        input  rx_empty, r_data, tx_full,
        output rd_uart, w_data, wr_uart
    );

    modport slave (
        output rx_empty, r_data, tx_full,
        input  rd_uart, w_data, wr_uart
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// Command responder: pops host frames from the RX FIFO, performs register
// reads/writes on a small register file, and pushes one reply byte per frame.
module uart_cmd_responder #(
    parameter int DBIT    = 8,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                         clk,
    input  logic                         reset,
    uart_cmd_responder_if.master         bus,
    output logic [8*(2**ADDR_W)-1:0]     regs,
    output logic                         busy,
    output logic                         timeout_err
);
    localparam int NREG  = 2**ADDR_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [DBIT-1:0] OP_WRITE = 8'h57;
    localparam logic [DBIT-1:0] OP_READ  = 8'h52;
    localparam logic [DBIT-1:0] RSP_ACK  = 8'h4B;
    localparam logic [DBIT-1:0] RSP_ERR  = 8'h3F;

    typedef enum logic [1:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        SEND
    } state_t;

    state_t             state;
    logic [DBIT-1:0]    reg_file [NREG];
    logic [ADDR_W-1:0]  addr_q;
    logic               addr_ok_q;
    logic               is_write;
    logic [DBIT-1:0]    w_data_q;
    logic [CNT_W-1:0]   idle_cnt;
    logic               pop;
    logic               addr_ok;
    logic               cnt_expired;

    // Pop whenever a byte is waiting and we are collecting a frame; held low
    // during reset so the strobe drops asynchronously with everything else.
    assign pop         = reset && (state != SEND) && !bus.rx_empty;
    assign addr_ok     = (bus.r_data[DBIT-1:ADDR_W] == '0);
    assign cnt_expired = (idle_cnt == CNT_W'(TIMEOUT - 1));

    assign bus.rd_uart = pop;
    assign bus.wr_uart = (state == SEND) && !bus.tx_full;
    assign bus.w_data  = w_data_q;
    assign busy        = (state != IDLE);

    // Frame sequencer, register file, reply byte and inter-byte timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            addr_ok_q   <= 1'b0;
            is_write    <= 1'b0;
            w_data_q    <= '0;
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
            for (int unsigned k = 0; k < NREG; k++) begin
                reg_file[k] <= '0;
            end
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (pop) begin
                        if (bus.r_data == OP_WRITE || bus.r_data == OP_READ) begin
                            is_write <= (bus.r_data == OP_WRITE);
                            state    <= GET_ADDR;
                        end else begin
                            w_data_q <= RSP_ERR;
                            state    <= SEND;
                        end
                    end
                end
                GET_ADDR: begin
                    if (pop) begin
                        idle_cnt <= '0;
                        if (is_write) begin
                            addr_q    <= bus.r_data[ADDR_W-1:0];
                            addr_ok_q <= addr_ok;
                            state     <= GET_DATA;
                        end else begin
                            w_data_q <= addr_ok ? reg_file[bus.r_data[ADDR_W-1:0]] : RSP_ERR;
                            state    <= SEND;
                        end
                    end else if (cnt_expired) begin
                        idle_cnt    <= '0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                GET_DATA: begin
                    if (pop) begin
                        idle_cnt <= '0;
                        if (addr_ok_q) begin
                            reg_file[addr_q] <= bus.r_data;
                            w_data_q         <= RSP_ACK;
                        end else begin
                            w_data_q <= RSP_ERR;
                        end
                        state <= SEND;
                    end else if (cnt_expired) begin
                        idle_cnt    <= '0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                SEND: begin
                    idle_cnt <= '0;
                    if (!bus.tx_full) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flatten the register file onto the output bus, reg k at [8k+7:8k].
    always_comb begin
        regs = '0;
        for (int unsigned k = 0; k < NREG; k++) begin
            regs[8*k +: 8] = reg_file[k];
        end
    end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder with a behavioural RX/TX FIFO model.
module tb_uart_cmd_responder;
    logic clk;
    logic reset;
    logic [127:0] regs;
    logic busy;
    logic timeout_err;

    int checks;
    int errors;

    uart_cmd_responder_if #(.DBIT(8)) bus ();

    uart_cmd_responder #(
        .DBIT(8),
        .ADDR_W(4),
        .TIMEOUT(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .regs(regs),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model and event log
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int         tx_cyc[$];
    int         pop_cyc[$];
    int         cyc;
    int         n_to;
    int         to_cyc;
    int         last_pop_cyc;
    bit         pop_now;
    bit         push_now;
    logic [7:0] push_val;

    initial begin
        cyc = 0; n_to = 0; to_cyc = 0; last_pop_cyc = 0;
        pop_now = 0; push_now = 0; push_val = '0;
    end

    always @(posedge clk) begin
        cyc++;
        pop_now  = bus.rd_uart;
        push_now = bus.wr_uart;
        push_val = bus.w_data;
    end

    always @(negedge clk) begin
        if (pop_now && rx_q.size() > 0) begin
            void'(rx_q.pop_front());
            pop_cyc.push_back(cyc);
            last_pop_cyc = cyc;
        end
        if (push_now) begin
            tx_q.push_back(push_val);
            tx_cyc.push_back(cyc);
        end
        if (timeout_err) begin
            n_to++;
            to_cyc = cyc;
        end
        pop_now  = 0;
        push_now = 0;
        bus.rx_empty = (rx_q.size() == 0);
        bus.r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        tx_q.delete();
        tx_cyc.delete();
        pop_cyc.delete();
        n_to = 0;
    endtask

    task automatic wait_tx(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (tx_q.size() >= n) begin
                ok = 1;
                break;
            end
            step(1);
        end
    endtask

    task automatic wait_rx_drained(output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (rx_q.size() == 0) begin
                ok = 1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.tx_full = 1'b0;
        bus.rx_empty = 1'b1;
        bus.r_data = 8'h00;
        step(3);
        checks++;
        if ({bus.rd_uart, bus.wr_uart, busy, timeout_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000", {bus.rd_uart, bus.wr_uart, busy, timeout_err});
        end
        checks++;
        if (bus.w_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_wdata got %h want 00", bus.w_data);
        end
        checks++;
        if (regs !== 128'h0) begin
            errors++;
            $display("FAIL reset_regs got %h want 0", regs);
        end
        reset = 1'b1;
        step(2);
    endtask

    task automatic test_write_read();
        bit ok;
        logic [127:0] exp;
        clear_logs();
        exp = '0;
        exp[31:24] = 8'hA5;
        rx_q.push_back(8'h57); rx_q.push_back(8'h03); rx_q.push_back(8'hA5);
        rx_q.push_back(8'h52); rx_q.push_back(8'h03);
        wait_tx(2, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wr_rd_timeout got %0d bytes want 2", tx_q.size());
        end else begin
            checks++;
            if (tx_q[0] !== 8'h4B) begin
                errors++;
                $display("FAIL wr_ack got %h want 4b", tx_q[0]);
            end
            checks++;
            if (tx_q[1] !== 8'hA5) begin
                errors++;
                $display("FAIL rd_data got %h want a5", tx_q[1]);
            end
        end
        step(2);
        checks++;
        if (regs !== exp) begin
            errors++;
            $display("FAIL wr_regs got %h want %h", regs, exp);
        end
    endtask

    task automatic test_bad();
        bit ok;
        logic [127:0] exp;
        clear_logs();
        exp = '0;
        exp[31:24] = 8'hA5;
        rx_q.push_back(8'h41);
        rx_q.push_back(8'h57); rx_q.push_back(8'h13); rx_q.push_back(8'hFF);
        rx_q.push_back(8'h52); rx_q.push_back(8'h10);
        wait_tx(3, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bad_timeout got %0d bytes want 3", tx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (tx_q[i] !== 8'h3F) begin
                    errors++;
                    $display("FAIL bad_rsp%0d got %h want 3f", i, tx_q[i]);
                end
            end
        end
        step(3);
        checks++;
        if (tx_q.size() != 3) begin
            errors++;
            $display("FAIL bad_count got %0d want 3", tx_q.size());
        end
        checks++;
        if (regs !== exp) begin
            errors++;
            $display("FAIL bad_regs got %h want %h", regs, exp);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int viol;
        clear_logs();
        bus.tx_full = 1'b1;
        rx_q.push_back(8'h52); rx_q.push_back(8'h00); rx_q.push_back(8'h57);
        step(5);
        viol = 0;
        for (int i = 0; i < 45; i++) begin
            if (bus.wr_uart !== 1'b0 || bus.rd_uart !== 1'b0) viol++;
            step(1);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL bp_strobes got %0d active cycles want 0", viol);
        end
        checks++;
        if (rx_q.size() != 1 || tx_q.size() != 0) begin
            errors++;
            $display("FAIL bp_queues got rx=%0d tx=%0d want rx=1 tx=0", rx_q.size(), tx_q.size());
        end
        bus.tx_full = 1'b0;
        wait_tx(1, ok);
        step(3);
        checks++;
        if (!ok || tx_q.size() != 1 || tx_q[0] !== 8'h00) begin
            errors++;
            $display("FAIL bp_push got %0d bytes first %h want 1 byte 00", tx_q.size(),
                     (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
        end
        checks++;
        if (pop_cyc.size() < 3 || tx_cyc.size() < 1 || pop_cyc[2] != tx_cyc[0] + 1) begin
            errors++;
            $display("FAIL bp_next_pop got pops=%0d want opcode pop one cycle after push", pop_cyc.size());
        end
        // finish the queued write (regs[0] <= 00, unchanged)
        rx_q.push_back(8'h00); rx_q.push_back(8'h00);
        wait_tx(2, ok);
        checks++;
        if (!ok || tx_q[1] !== 8'h4B) begin
            errors++;
            $display("FAIL bp_tail got %0d bytes want 2 ending 4b", tx_q.size());
        end
        step(2);
    endtask

    task automatic test_timeout();
        bit ok;
        clear_logs();
        rx_q.push_back(8'h57); rx_q.push_back(8'h05);
        wait_rx_drained(ok);
        step(28);
        checks++;
        if (!ok || n_to != 1) begin
            errors++;
            $display("FAIL to_pulses got %0d want 1", n_to);
        end
        checks++;
        if (to_cyc - last_pop_cyc != 20) begin
            errors++;
            $display("FAIL to_delay got %0d want 20", to_cyc - last_pop_cyc);
        end
        checks++;
        if (tx_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_abort got tx=%0d busy=%b want tx=0 busy=0", tx_q.size(), busy);
        end
        rx_q.push_back(8'h52); rx_q.push_back(8'h05);
        wait_tx(1, ok);
        checks++;
        if (!ok || tx_q[0] !== 8'h00) begin
            errors++;
            $display("FAIL to_read got %0d bytes want 1 byte 00", tx_q.size());
        end
        step(2);
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_logs();
        rx_q.push_back(8'h57); rx_q.push_back(8'h02); rx_q.push_back(8'h7E);
        wait_tx(1, ok);
        step(2);
        checks++;
        if (!ok || regs[23:16] !== 8'h7E) begin
            errors++;
            $display("FAIL rm_pre got %h want 7e", regs[23:16]);
        end
        rx_q.push_back(8'h57); rx_q.push_back(8'h02);
        wait_rx_drained(ok);
        step(1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rm_busy got %b want 1", busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.rd_uart, bus.wr_uart, busy, timeout_err} !== 4'b0000 ||
            bus.w_data !== 8'h00 || regs !== 128'h0) begin
            errors++;
            $display("FAIL rm_async got ctl=%b wdata=%h regs=%h want all 0",
                     {bus.rd_uart, bus.wr_uart, busy, timeout_err}, bus.w_data, regs);
        end
        step(1);
        reset = 1'b1;
        step(1);
        clear_logs();
        rx_q.push_back(8'h52); rx_q.push_back(8'h02);
        wait_tx(1, ok);
        checks++;
        if (!ok || tx_q[0] !== 8'h00) begin
            errors++;
            $display("FAIL rm_read got %0d bytes want 1 byte 00", tx_q.size());
        end
        step(2);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bad_rsp;
        int bad_gap;
        logic [127:0] exp;
        logic [7:0] v;
        clear_logs();
        exp = '0;
        for (int k = 0; k < 16; k++) begin
            v = 8'(k * 17);
            exp[8*k +: 8] = v;
            rx_q.push_back(8'h57); rx_q.push_back(8'(k)); rx_q.push_back(v);
        end
        wait_tx(16, ok);
        step(2);
        checks++;
        if (!ok || tx_q.size() != 16) begin
            errors++;
            $display("FAIL b2b_count got %0d want 16", tx_q.size());
        end else begin
            bad_rsp = 0;
            bad_gap = 0;
            for (int i = 0; i < 16; i++) begin
                if (tx_q[i] !== 8'h4B) bad_rsp++;
                if (i > 0 && tx_cyc[i] - tx_cyc[i-1] != 4) bad_gap++;
            end
            checks++;
            if (bad_rsp != 0) begin
                errors++;
                $display("FAIL b2b_rsp got %0d non-4b bytes want 0", bad_rsp);
            end
            checks++;
            if (bad_gap != 0) begin
                errors++;
                $display("FAIL b2b_period got %0d gaps not 4 want 0", bad_gap);
            end
        end
        checks++;
        if (regs !== exp) begin
            errors++;
            $display("FAIL b2b_regs got %h want %h", regs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_bad();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
